serial_word_equal_ctrl: RTL and testbench
=========================================

# serial_word_equal_ctrl

Multi-cycle equality checker for WIDTH-bit words built around a single shared `two_bit_equal` slice comparator. On a start request it captures both operands and steps the comparator across 2-bit slices, LSB slice first, one slice per clock. It stops early on the first mismatching slice and reports the result with a one-cycle done pulse. It is the sequencing controller that lets wide-word compares reuse the 2-bit equality datapath instead of instantiating a full-width comparator tree.

## Interface
- WIDTH, 8: operand width in bits. Must be even and ≥2. Number of slices S = WIDTH/2.
- IW, max($clog2(S),1): slice-index width (localparam, derived).

- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- start  input  1  request a compare; honoured only in IDLE.
- a  input  WIDTH  operand A; sampled only on the accepting edge.
- b  input  WIDTH  operand B; sampled only on the accepting edge.
- busy  output  1  high while a compare is in progress (CMP state).
- done  output  1  one-cycle pulse; result outputs are valid.
- aeqb  output  1  1 = last completed compare found a == b; held until the next accepted start.
- diff_slice  output  IW  index of the first mismatching slice; 0 when aeqb = 1; held like aeqb.

## Operation
- States:
  - IDLE: waiting for start.
  - CMP: comparing slices.
  - DONE: single-cycle result state.
- Internal registers:
  - ra, rb (WIDTH): captured operands.
  - idx (IW): current slice index.
- Exactly one `two_bit_equal` instance, driven by ra[2*idx+1 : 2*idx] and rb[2*idx+1 : 2*idx]. Its output is `e`.
- IDLE:
  - start = 1 → ra ← a, rb ← b, idx ← 0, aeqb ← 0, diff_slice ← 0, go to CMP.
  - Otherwise stay in IDLE.
- CMP (evaluated each edge):
  - e = 0 → aeqb ← 0, diff_slice ← idx, go to DONE.
  - e = 1 and idx = S−1 → aeqb ← 1, diff_slice ← 0, go to DONE.
  - e = 1 and idx < S−1 → idx ← idx+1, stay in CMP.
- DONE: done = 1 for this cycle only, then go to IDLE unconditionally.
- Decoding:
  - busy = (state == CMP).
  - done = (state == DONE).
  - Both are decoded directly from the registered state.
- start in CMP or DONE is ignored and is not queued. Operand changes after the accepting edge have no effect.
- idx never exceeds S−1; there is no wrap-around.
- WIDTH = 2: S = 1, so CMP lasts exactly one cycle.
- reset (any state, including mid-compare) → state IDLE. At the same edge, all registers clear to 0: busy 0, done 0, aeqb 0, diff_slice 0, idx 0, ra 0, rb 0.
- reset together with start: reset wins and the start is dropped.

## Timing
- Edge numbering: edge k is the edge that accepts start. busy is high from after edge k.
- Equal operands: CMP occupies edges k+1 … k+S.
  - done is high in the cycle following edge k+S, i.e. S+1 edges after acceptance.
- Mismatch first found in slice i: done is high after edge k+i+1, i.e. i+2 edges after acceptance.
- aeqb and diff_slice update on the edge entering DONE. They are therefore valid in the same cycle as done.
- Earliest new acceptance: start is sampled high on the edge leaving DONE… no — only in IDLE. The back-to-back minimum is one IDLE cycle. Start may be held high through DONE and is then accepted on the first IDLE edge.
- Throughput:
  - Worst case: S+2 cycles per compare.
  - Best case: 3 cycles per compare.

## Test plan
- Reset: hold reset for 2 cycles → busy = done = aeqb = 0, diff_slice = 0, no done pulse afterwards.
- Equal operands: WIDTH = 8, a = b = 8'hA5, pulse start → busy for 4 cycles, done 5 edges after acceptance, aeqb = 1, diff_slice = 0.
- Early mismatch: a = 8'h01, b = 8'h00 → done 2 edges after acceptance, aeqb = 0, diff_slice = 0. A second case, a = 8'h80, b = 8'h00 → done at 5 edges, diff_slice = 3.
- Ignored inputs while busy:
  - Accept with a = b = 8'h3C, then change b to 8'hFF and pulse start during CMP → result is aeqb = 1 and only one done pulse occurs.
  - Hold start high continuously → the next compare is accepted on the IDLE edge after done.
- Reset mid-compare: assert reset at the 2nd CMP cycle → next cycle IDLE with all outputs 0 and no done pulse. A subsequent compare of 8'h12 vs 8'h12 then completes normally with aeqb = 1.
- WIDTH = 2 instance:
  - a = b = 2'b10 → done 2 edges after acceptance, aeqb = 1.
  - a = 2'b10, b = 2'b11 → aeqb = 0, diff_slice = 0.

Source files
------------

// File: rtl/serial_word_equal_ctrl.sv
// Multi-cycle word equality checker. A single 2-bit slice comparator is
// stepped across the captured operands, LSB slice first, stopping at the
// first mismatching slice and reporting the result with a one-cycle done.

// 2-bit slice equality comparator shared by the sequencer below.
module two_bit_equal (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       e
);

  assign e = (a == b);

endmodule

module serial_word_equal_ctrl #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned S  = WIDTH / 2,
  localparam int unsigned IW = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          aeqb,
  output logic [IW-1:0] diff_slice
);

  localparam logic [IW-1:0] LastIdx = IW'(S - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCmp,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             aeqb_q, aeqb_d;
  logic [IW-1:0]    diff_q, diff_d;

  logic [1:0] slice_a;
  logic [1:0] slice_b;
  logic       e;

  // Select the current 2-bit slice of each captured operand.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < int'(S); i++) begin
      if (idx_q == IW'(i)) begin
        slice_a = ra_q[2*i +: 2];
        slice_b = rb_q[2*i +: 2];
      end
    end
  end

  two_bit_equal u_slice_cmp (
    .a (slice_a),
    .b (slice_b),
    .e (e)
  );

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      aeqb_q  <= 1'b0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      aeqb_q  <= aeqb_d;
      diff_q  <= diff_d;
    end
  end

  // Next-state and datapath update; status decoded from registered state.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    aeqb_d  = aeqb_q;
    diff_d  = diff_q;
    busy    = (state_q == StCmp);
    done    = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          idx_d   = '0;
          aeqb_d  = 1'b0;
          diff_d  = '0;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (!e) begin
          aeqb_d  = 1'b0;
          diff_d  = idx_q;
          state_d = StDone;
        end else if (idx_q == LastIdx) begin
          aeqb_d  = 1'b1;
          diff_d  = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign aeqb       = aeqb_q;
  assign diff_slice = diff_q;

endmodule

// File: tb/tb_serial_word_equal_ctrl.sv
// Directed bench for serial_word_equal_ctrl: an 8-bit and a 2-bit instance.
module tb_serial_word_equal_ctrl;

  logic       clk;
  logic       reset;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, aeqb8;
  logic [1:0] diff8;
  logic       busy2, done2, aeqb2;
  logic       diff2;

  int n_cmp;
  int n_bad;

  serial_word_equal_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .aeqb       (aeqb8),
    .diff_slice (diff8)
  );

  serial_word_equal_ctrl #(.WIDTH(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .a          (a2),
    .b          (b2),
    .busy       (busy2),
    .done       (done2),
    .aeqb       (aeqb2),
    .diff_slice (diff2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one 8-bit compare; edges counted including the accepting edge.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input int exp_edges, input logic exp_eq, input logic [1:0] exp_diff);
    int n;
    int nbusy;
    a8 = av;
    b8 = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 1;
    nbusy = 0;
    check({tag, "_busy_after_accept"}, 32'(busy8), 32'd1);
    check({tag, "_aeqb_cleared"}, 32'(aeqb8), 32'd0);
    while (!done8 && n < 40) begin
      if (busy8) nbusy++;
      tick();
      n++;
    end
    check({tag, "_edges"}, 32'(n), 32'(exp_edges));
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_edges - 1));
    check({tag, "_aeqb"}, 32'(aeqb8), 32'(exp_eq));
    check({tag, "_diff"}, 32'(diff8), 32'(exp_diff));
    tick();
    check({tag, "_done_single"}, 32'(done8), 32'd0);
    check({tag, "_aeqb_held"}, 32'(aeqb8), 32'(exp_eq));
  endtask

  task automatic run2(input string tag, input logic [1:0] av, input logic [1:0] bv,
                      input int exp_edges, input logic exp_eq, input logic exp_diff);
    int n;
    a2 = av;
    b2 = bv;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1;
    check({tag, "_busy_after_accept"}, 32'(busy2), 32'd1);
    while (!done2 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_edges"}, 32'(n), 32'(exp_edges));
    check({tag, "_aeqb"}, 32'(aeqb2), 32'(exp_eq));
    check({tag, "_diff"}, 32'(diff2), 32'(exp_diff));
    tick();
    check({tag, "_done_single"}, 32'(done2), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start8 = 1'b0;
    start2 = 1'b0;
    a8 = '0;
    b8 = '0;
    a2 = '0;
    b2 = '0;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_aeqb", 32'(aeqb8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    check("rst_quiet", 32'(ndone), 32'd0);

    run8("eq_a5", 8'hA5, 8'hA5, 5, 1'b1, 2'd0);
    run8("mis_s0", 8'h01, 8'h00, 2, 1'b0, 2'd0);
    run8("mis_s3", 8'h80, 8'h00, 5, 1'b0, 2'd3);
    run8("mis_s2", 8'h00, 8'h10, 4, 1'b0, 2'd2);
    run8("mis_s1", 8'hF3, 8'hFF, 3, 1'b0, 2'd1);

    // Operand change and extra start during CMP are ignored.
    a8 = 8'h3C;
    b8 = 8'h3C;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    b8 = 8'hFF;
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    ndone = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("ign_aeqb", 32'(aeqb8), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done8 || busy8) ndone++;
    end
    check("ign_no_second", 32'(ndone), 32'd0);

    // Start held high: next accept on the IDLE edge after done.
    a8 = 8'h01;
    b8 = 8'h00;
    start8 = 1'b1;
    tick();
    tick();
    check("hold_done1", 32'(done8), 32'd1);
    tick();
    check("hold_idle_busy", 32'(busy8), 32'd0);
    check("hold_idle_done", 32'(done8), 32'd0);
    tick();
    check("hold_reaccept", 32'(busy8), 32'd1);
    start8 = 1'b0;
    tick();
    check("hold_done2", 32'(done8), 32'd1);
    tick();

    // Reset in the second CMP cycle.
    a8 = 8'hFF;
    b8 = 8'hFF;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    check("midrst_pre_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_aeqb", 32'(aeqb8), 32'd0);
    check("midrst_diff", 32'(diff8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run8("post_rst_eq", 8'h12, 8'h12, 5, 1'b1, 2'd0);

    // Reset together with start: start dropped.
    start8 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start8 = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);
    tick();
    check("rst_start_idle", 32'(busy8), 32'd0);

    run2("w2_eq", 2'b10, 2'b10, 2, 1'b1, 1'b0);
    run2("w2_mis", 2'b10, 2'b11, 2, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
